// File: rtl/program_loader.sv
// program_loader
//
// Boot-time writer for the instruction memory. Consumes a byte stream made of a
// little-endian 32-bit word-count header followed by that many little-endian
// 32-bit instruction words. Each word is written to program memory at
// consecutive byte addresses starting at TEXT_BASE. The processor is held in
// reset for the whole load and released once the final word has been written.
//
// Ports
//   clk         in   clock, all state changes on the rising edge
//   reset       in   asynchronous active-low reset
//   byte_in     in   stream data byte
//   byte_valid  in   byte_in holds a valid byte
//   byte_ready  out  loader accepts a byte this cycle (HDR and LOAD only)
//   wr_en       out  single-cycle program-memory write strobe
//   wr_addr     out  absolute byte address of the write (held when wr_en=0)
//   wr_data     out  assembled instruction word (held when wr_en=0)
//   cpu_hold    out  1 keeps the processor in reset
//   load_done   out  load finished successfully (sticky until reset)
//   load_error  out  header count exceeded MAX_WORDS (sticky until reset)

module program_loader #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  TEXT_BASE  = 32'h0040_0000,
  parameter int unsigned            MAX_WORDS  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error
);

  // Index is wide enough to hold MAX_WORDS itself.
  localparam int unsigned IDX_W = $clog2(MAX_WORDS) + 1;

  localparam logic [2:0] S_HDR   = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_LAST  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  logic [2:0]            r_state,    w_state_nxt;
  logic [1:0]            r_byte_cnt, w_byte_cnt_nxt;
  logic [DATA_WIDTH-9:0] r_shift,    w_shift_nxt;
  logic [31:0]           r_count,    w_count_nxt;
  logic [IDX_W-1:0]      r_index,    w_index_nxt;
  logic                  r_wr_en,    w_wr_en_nxt;
  logic [ADDR_WIDTH-1:0] r_wr_addr,  w_wr_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wr_data,  w_wr_data_nxt;

  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_word;
  logic [IDX_W-1:0]      w_index_inc;
  logic [ADDR_WIDTH-1:0] w_offset;

  assign byte_ready = (r_state == S_HDR) || (r_state == S_LOAD);
  assign w_accept   = byte_valid && byte_ready;

  // The 4th byte completes the word combinationally, so it can be acted on at
  // the same edge that accepts it.
  assign w_word      = {byte_in, r_shift};
  assign w_index_inc = r_index + 1'b1;
  assign w_offset    = ADDR_WIDTH'({r_index, 2'b00});

  always_comb begin
    w_state_nxt    = r_state;
    w_byte_cnt_nxt = r_byte_cnt;
    w_shift_nxt    = r_shift;
    w_count_nxt    = r_count;
    w_index_nxt    = r_index;
    w_wr_en_nxt    = 1'b0;
    w_wr_addr_nxt  = r_wr_addr;
    w_wr_data_nxt  = r_wr_data;

    if (w_accept) begin
      w_byte_cnt_nxt = r_byte_cnt + 2'd1;
      unique case (r_byte_cnt)
        2'd0: w_shift_nxt[7:0]   = byte_in;
        2'd1: w_shift_nxt[15:8]  = byte_in;
        2'd2: w_shift_nxt[23:16] = byte_in;
        default: begin
          if (r_state == S_HDR) begin
            w_count_nxt = 32'(w_word);
            w_index_nxt = '0;
            if (w_word == '0) begin
              w_state_nxt = S_DONE;
            end else if (32'(w_word) > 32'(MAX_WORDS)) begin
              w_state_nxt = S_ERROR;
            end else begin
              w_state_nxt = S_LOAD;
            end
          end else begin
            w_wr_en_nxt   = 1'b1;
            w_wr_data_nxt = w_word;
            w_wr_addr_nxt = TEXT_BASE + w_offset;
            w_index_nxt   = w_index_inc;
            if (32'(w_index_inc) == r_count) begin
              w_state_nxt = S_LAST;
            end
          end
        end
      endcase
    end

    // LAST only exists to keep the release one cycle behind the final write.
    if (r_state == S_LAST) begin
      w_state_nxt = S_DONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_HDR;
      r_byte_cnt <= 2'd0;
      r_shift    <= '0;
      r_count    <= '0;
      r_index    <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= TEXT_BASE;
      r_wr_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_count    <= w_count_nxt;
      r_index    <= w_index_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign cpu_hold   = (r_state != S_DONE);
  assign load_done  = (r_state == S_DONE);
  assign load_error = (r_state == S_ERROR);

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time writer for the instruction memory. It accepts a byte stream carrying a little-endian 32-bit word-count header followed by that many little-endian 32-bit instruction words. It writes each word to program memory at consecutive byte addresses starting at the text-segment base. While loading it holds the processor in reset, and it releases the processor once the last word has been written.

## Interface
Parameters:
- DATA_WIDTH, 32: instruction word width (fixed at 32; 4 bytes per word).
- ADDR_WIDTH, 32: width of the write address.
- TEXT_BASE, 32'h00400000: absolute byte address of the first instruction.
- MAX_WORDS, 64: largest accepted word count; a header above this is an error.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- byte_in  input  8  stream data byte.
- byte_valid  input  1  byte_in holds a valid byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  one-cycle write strobe to program memory.
- wr_addr  output  ADDR_WIDTH  absolute byte address of the write (TEXT_BASE + 4·index).
- wr_data  output  DATA_WIDTH  assembled instruction word.
- cpu_hold  output  1  1 holds the processor in reset.
- load_done  output  1  load completed successfully (sticky).
- load_error  output  1  header exceeded MAX_WORDS (sticky).

## Operation
- **Handshake.** A byte transfers on a rising edge where byte_valid && byte_ready. byte_ready is a decode of state: 1 in HDR and LOAD, 0 otherwise.
- **Byte assembly.** Bytes are assembled little-endian. The first byte of a group goes to bits [7:0] and the 4th to [31:24]. A 2-bit byte counter wraps 3→0 on each completed word.
- **States.** HDR, LOAD, LAST, DONE, ERROR.
- **HDR.**
  - Collect 4 bytes into N, a 32-bit count.
  - On the edge accepting the 4th byte: N==0 → DONE; N>MAX_WORDS → ERROR; else → LOAD with word index = 0.
- **LOAD.**
  - Collect 4 bytes.
  - On the edge accepting the 4th byte, register wr_en=1, wr_data=assembled word and wr_addr=TEXT_BASE+4·index, then increment index.
  - If the incremented index equals N → LAST; else stay in LOAD.
  - Byte acceptance continues in the cycle wr_en is high; there is no stall between words.
- **LAST.**
  - wr_en is high for the final word; byte_ready=0.
  - Unconditional → DONE next edge.
- **DONE.** cpu_hold=0, load_done=1, byte_ready=0. Stays here until reset; further bytes are ignored.
- **ERROR.** cpu_hold=1, load_error=1, byte_ready=0. Stays here until reset. No write is ever issued.
- **Write strobe.** wr_en is a single-cycle pulse per word. wr_addr and wr_data hold their last values when wr_en=0.
- **Arithmetic.** Address arithmetic is ADDR_WIDTH wide, unsigned. The index counter is clog2(MAX_WORDS)+1 bits, so MAX_WORDS itself is representable.
- **Reset.** Reset mid-operation discards any partial word and header. The loader returns to HDR and performs no further writes.

## Timing
- **Reset values.** State=HDR, byte_ready=1, wr_en=0, wr_addr=TEXT_BASE, wr_data=0, cpu_hold=1, load_done=0, load_error=0.
- **Write latency.** wr_en goes high in the cycle after the edge that accepted the 4th byte of a word.
- **Throughput.** One byte per cycle, so back-to-back words produce a wr_en pulse every 4 cycles.
- **Release timing.**
  - cpu_hold falls and load_done rises exactly one cycle after the final wr_en pulse.
  - The CPU is never released in the same cycle as a write.
  - For N==0, cpu_hold falls on the cycle after the 4th header byte is accepted.
- **Error timing.** load_error rises in the cycle after the 4th header byte; byte_ready drops in the same cycle.
- **Stalls.** byte_valid may drop at any time; partial bytes-of-word state is held indefinitely.

## Test plan
- **Normal load, back to back.** Header 02 00 00 00, then 13 00 00 20 and 08 00 10 00, sent back to back → wr_en pulses:
  - (0x00400000, 0x20000013)
  - (0x00400004, 0x00100008)
  - cpu_hold 1→0 and load_done=1 one cycle after the 2nd pulse.
- **Empty load.** Header 00 00 00 00 → no wr_en; cpu_hold=0 and load_done=1 the cycle after the 4th byte; byte_ready=0 afterward.
- **Oversize header.** Header 41 00 00 00 with MAX_WORDS=64 → load_error=1, cpu_hold stays 1, byte_ready=0; 8 further valid bytes produce no wr_en.
- **Stalled input.** Header=1, then word bytes AA BB CC DD with byte_valid gaps of 3 cycles between bytes → one wr_en with wr_data=0xDDCCBBAA at 0x00400000.
- **Reset mid-load.**
  - Header=2; send 6 data bytes; assert reset.
  - Outputs return to their reset values.
  - Header=1 plus 11 22 33 44 → a single write of 0x44332211 at 0x00400000.
- **Exact limit.** Header=64 with 64 words → last write at 0x004000FC, then load_done=1 and load_error=0.
